// File: rtl/ar_arbiter_rr_slice_if.sv
// AR-channel bundle between the master-side request ports and the arbiter slice.
// The master modport drives requests and slave ready; the slave modport is the arbiter.
interface ar_arbiter_rr_slice_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int TRANS_PROT  = 3,
    parameter int NUM_MASTERS = 16
);
    localparam int IDX_WIDTH = $clog2(NUM_MASTERS);

    logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_axi_araddr_i;
    logic [NUM_MASTERS-1:0]            m_axi_arvalid_i;
    logic [NUM_MASTERS-1:0]            m_axi_arready_o;
    logic [TRANS_PROT*NUM_MASTERS-1:0] m_axi_arprot_i;
    logic [ADDR_WIDTH-1:0]             s_axi_araddr_o;
    logic                              s_axi_arvalid_o;
    logic                              s_axi_arready_i;
    logic [TRANS_PROT-1:0]             s_axi_arprot_o;
    logic [NUM_MASTERS-1:0]            Master_ID_Selected_o;
    logic [IDX_WIDTH-1:0]              Master_ID_Index_o;

    modport master (
        output m_axi_araddr_i, m_axi_arvalid_i, m_axi_arprot_i, s_axi_arready_i,
        input  m_axi_arready_o, s_axi_araddr_o, s_axi_arvalid_o, s_axi_arprot_o,
               Master_ID_Selected_o, Master_ID_Index_o
    );

    modport slave (
        input  m_axi_araddr_i, m_axi_arvalid_i, m_axi_arprot_i, s_axi_arready_i,
        output m_axi_arready_o, s_axi_araddr_o, s_axi_arvalid_o, s_axi_arprot_o,
               Master_ID_Selected_o, Master_ID_Index_o
    );
endinterface

// File: rtl/ar_arbiter_rr_slice.sv
// Registered round-robin AXI-Lite AR arbiter with output slice; define AR_ARB_WEIGHTED_EN
// to enable per-master weighted re-grants driven by M_WEIGHTS.
module ar_arbiter_rr_slice #(
    parameter int ADDR_WIDTH   = 32,
    parameter int TRANS_PROT   = 3,
    parameter int NUM_MASTERS  = 16,
    parameter int WEIGHT_WIDTH = 4,
    parameter logic [NUM_MASTERS*WEIGHT_WIDTH-1:0] M_WEIGHTS = {NUM_MASTERS{4'd1}}
) (
    input  logic m_axi_aclk_i,
    input  logic m_axi_areset_i,
    ar_arbiter_rr_slice_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [NUM_MASTERS-1:0] sel_reg, sel_next;
    logic [NUM_MASTERS-1:0] arready_reg, arready_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [TRANS_PROT-1:0]  prot_reg, prot_next;
    logic                   valid_reg, valid_next;

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_MASTERS];
    logic [TRANS_PROT-1:0]  prot_arr [NUM_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign addr_arr[gi] = bus.m_axi_araddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign prot_arr[gi] = bus.m_axi_arprot_i[gi*TRANS_PROT +: TRANS_PROT];
        end
    endgenerate

`ifdef AR_ARB_WEIGHTED_EN
    logic [WEIGHT_WIDTH-1:0] credit_reg, credit_next;
    logic [WEIGHT_WIDTH-1:0] weight_arr [NUM_MASTERS];
    logic                    stay;

    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_weight
            assign weight_arr[gi] = (M_WEIGHTS[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                                  ? WEIGHT_WIDTH'(1)
                                  : M_WEIGHTS[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    endgenerate

    // credit==0 means nothing has been granted since reset, so no re-grant is owed.
    assign stay = (credit_reg != '0) && bus.m_axi_arvalid_i[rr_ptr_reg]
               && (credit_reg < weight_arr[rr_ptr_reg]);
`else
    logic unused_weights;
    assign unused_weights = ^M_WEIGHTS;
`endif

    // First valid request strictly after rr_ptr, wrapping; lowest offset wins.
    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;

    always_comb begin : rr_search
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = IDX_W'(cand);
            if (bus.m_axi_arvalid_i[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    logic             win_any;
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        idx_next     = idx_reg;
        sel_next     = sel_reg;
        arready_next = '0;
        addr_next    = addr_reg;
        prot_next    = prot_reg;
        valid_next   = valid_reg;
        win_any      = 1'b0;
        win_idx      = '0;
`ifdef AR_ARB_WEIGHTED_EN
        credit_next  = credit_reg;
`endif
        case (state_reg)
            IDLE: begin
`ifdef AR_ARB_WEIGHTED_EN
                if (stay) begin
                    win_any     = 1'b1;
                    win_idx     = rr_ptr_reg;
                    credit_next = credit_reg + WEIGHT_WIDTH'(1);
                end else if (rr_found) begin
                    win_any     = 1'b1;
                    win_idx     = rr_idx;
                    credit_next = WEIGHT_WIDTH'(1);
                end
`else
                win_any = rr_found;
                win_idx = rr_idx;
`endif
                if (win_any) begin
                    state_next   = BUSY;
                    valid_next   = 1'b1;
                    idx_next     = win_idx;
                    sel_next     = NUM_MASTERS'(1) << win_idx;
                    arready_next = NUM_MASTERS'(1) << win_idx;
                    addr_next    = addr_arr[win_idx];
                    prot_next    = prot_arr[win_idx];
                end
            end
            BUSY: begin
                // Captured request is frozen until the slave takes it.
                if (bus.s_axi_arready_i) begin
                    state_next  = IDLE;
                    valid_next  = 1'b0;
                    idx_next    = '0;
                    sel_next    = '0;
                    addr_next   = '0;
                    prot_next   = '0;
                    rr_ptr_next = idx_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk_i or posedge m_axi_areset_i) begin
        if (m_axi_areset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge m_axi_aclk_i or posedge m_axi_areset_i) begin
        if (m_axi_areset_i) begin
            rr_ptr_reg  <= IDX_W'(NUM_MASTERS - 1);
            idx_reg     <= '0;
            sel_reg     <= '0;
            arready_reg <= '0;
            addr_reg    <= '0;
            prot_reg    <= '0;
            valid_reg   <= 1'b0;
`ifdef AR_ARB_WEIGHTED_EN
            credit_reg  <= '0;
`endif
        end else begin
            rr_ptr_reg  <= rr_ptr_next;
            idx_reg     <= idx_next;
            sel_reg     <= sel_next;
            arready_reg <= arready_next;
            addr_reg    <= addr_next;
            prot_reg    <= prot_next;
            valid_reg   <= valid_next;
`ifdef AR_ARB_WEIGHTED_EN
            credit_reg  <= credit_next;
`endif
        end
    end

    assign bus.m_axi_arready_o      = arready_reg;
    assign bus.s_axi_araddr_o       = addr_reg;
    assign bus.s_axi_arprot_o       = prot_reg;
    assign bus.s_axi_arvalid_o      = valid_reg;
    assign bus.Master_ID_Selected_o = sel_reg;
    assign bus.Master_ID_Index_o    = idx_reg;
endmodule

// File: tb/tb_ar_arbiter_rr_slice.sv
// Directed bench for ar_arbiter_rr_slice: per-cycle vector table plus reset and
// weighted-sequence scenarios on a second instance with m0=3, m1=1.
module tb_ar_arbiter_rr_slice;
    localparam int AW = 32;
    localparam int PW = 3;
    localparam int NM = 16;
    localparam int WW = 4;
    localparam logic [NM*WW-1:0] W_WEIGHTS = {{14{4'd1}}, 4'd1, 4'd3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ar_arbiter_rr_slice_if #(.ADDR_WIDTH(AW), .TRANS_PROT(PW), .NUM_MASTERS(NM)) bus ();
    ar_arbiter_rr_slice_if #(.ADDR_WIDTH(AW), .TRANS_PROT(PW), .NUM_MASTERS(NM)) bus_w ();

    ar_arbiter_rr_slice #(
        .ADDR_WIDTH(AW), .TRANS_PROT(PW), .NUM_MASTERS(NM), .WEIGHT_WIDTH(WW)
    ) dut (
        .m_axi_aclk_i(clk), .m_axi_areset_i(rst), .bus(bus)
    );

    ar_arbiter_rr_slice #(
        .ADDR_WIDTH(AW), .TRANS_PROT(PW), .NUM_MASTERS(NM), .WEIGHT_WIDTH(WW),
        .M_WEIGHTS(W_WEIGHTS)
    ) dut_w (
        .m_axi_aclk_i(clk), .m_axi_areset_i(rst), .bus(bus_w)
    );

    int tests  = 0;
    int failed = 0;
    int hs5000 = 0;

    always @(posedge clk) begin
        if (bus.s_axi_arvalid_o && bus.s_axi_arready_i && bus.s_axi_araddr_o == 32'h5000)
            hs5000 <= hs5000 + 1;
    end

    typedef struct {
        int          phase;
        logic [15:0] valid;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_sel;
        logic [15:0] exp_ardy;
        logic [31:0] exp_addr;
        logic [2:0]  exp_prot;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [15:0] es,
                                 input logic [15:0] ea, input logic [31:0] ead,
                                 input logic [2:0] ep, input logic [3:0] ei);
        check({tag, ".arvalid"}, 32'(bus.s_axi_arvalid_o), 32'(ev));
        check({tag, ".sel"},     32'(bus.Master_ID_Selected_o), 32'(es));
        check({tag, ".arready"}, 32'(bus.m_axi_arready_o), 32'(ea));
        check({tag, ".addr"},    bus.s_axi_araddr_o, ead);
        check({tag, ".prot"},    32'(bus.s_axi_arprot_o), 32'(ep));
        check({tag, ".idx"},     32'(bus.Master_ID_Index_o), 32'(ei));
    endtask

    task automatic set_addrs(input int phase);
        for (int i = 0; i < NM; i++) begin
            bus.m_axi_araddr_i[i*AW +: AW]   = 32'hF000_0000 + 32'(i);
            bus.m_axi_arprot_i[i*PW +: PW]   = 3'd7;
            bus_w.m_axi_araddr_i[i*AW +: AW] = 32'hE000_0000 + 32'(i);
            bus_w.m_axi_arprot_i[i*PW +: PW] = 3'd6;
        end
        case (phase)
            0: begin
                bus.m_axi_araddr_i[0*AW +: AW] = 32'h1000; bus.m_axi_arprot_i[0*PW +: PW] = 3'b001;
            end
            1: begin
                bus.m_axi_araddr_i[0*AW +: AW]  = 32'h2000; bus.m_axi_arprot_i[0*PW +: PW]  = 3'd2;
                bus.m_axi_araddr_i[5*AW +: AW]  = 32'h3000; bus.m_axi_arprot_i[5*PW +: PW]  = 3'd3;
                bus.m_axi_araddr_i[10*AW +: AW] = 32'h4000; bus.m_axi_arprot_i[10*PW +: PW] = 3'd4;
            end
            3: begin
                bus.m_axi_araddr_i[15*AW +: AW] = 32'h5000; bus.m_axi_arprot_i[15*PW +: PW] = 3'b101;
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.m_axi_arvalid_i   = '0;
        bus.s_axi_arready_i   = 1'b0;
        bus_w.m_axi_arvalid_i = '0;
        bus_w.s_axi_arready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int cur_phase;
        int base;
        int got[$];
        int exp_w[8];
`ifdef AR_ARB_WEIGHTED_EN
        exp_w = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
        exp_w = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        // Phase 0: lone master 0, slave ready on the third BUSY cycle.
        vecs.push_back('{0, 16'h0001, 1'b0, 1'b1, 16'h0001, 16'h0001, 32'h1000, 3'b001, 4'd0});
        vecs.push_back('{0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0000, 32'h1000, 3'b001, 4'd0});
        vecs.push_back('{0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0000, 32'h1000, 3'b001, 4'd0});
        vecs.push_back('{0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h0,    3'b000, 4'd0});
        vecs.push_back('{0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0,    3'b000, 4'd0});
        // Phase 1: masters 0, 5, 10 always valid, slave always ready.
        vecs.push_back('{1, 16'h0421, 1'b1, 1'b1, 16'h0001, 16'h0001, 32'h2000, 3'd2, 4'd0});
        vecs.push_back('{1, 16'h0421, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h0,    3'd0, 4'd0});
        vecs.push_back('{1, 16'h0421, 1'b1, 1'b1, 16'h0020, 16'h0020, 32'h3000, 3'd3, 4'd5});
        vecs.push_back('{1, 16'h0421, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h0,    3'd0, 4'd0});
        vecs.push_back('{1, 16'h0421, 1'b1, 1'b1, 16'h0400, 16'h0400, 32'h4000, 3'd4, 4'd10});
        vecs.push_back('{1, 16'h0421, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h0,    3'd0, 4'd0});
        vecs.push_back('{1, 16'h0421, 1'b1, 1'b1, 16'h0001, 16'h0001, 32'h2000, 3'd2, 4'd0});
        vecs.push_back('{1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h0,    3'd0, 4'd0});
        // Phase 2: no requests, slave ready asserted in IDLE.
        for (int i = 0; i < 5; i++)
            vecs.push_back('{2, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h0, 3'd0, 4'd0});

        set_addrs(0);
        do_reset();
        rst = 1'b1;
        #1;
        check_outputs("reset", 1'b0, 16'h0, 16'h0, 32'h0, 3'd0, 4'd0);
        rst = 1'b0;

        cur_phase = -1;
        foreach (vecs[i]) begin
            if (vecs[i].phase != cur_phase) begin
                cur_phase = vecs[i].phase;
                if (cur_phase != 2) do_reset();
                set_addrs(cur_phase);
            end
            bus.m_axi_arvalid_i = vecs[i].valid;
            bus.s_axi_arready_i = vecs[i].rdy;
            @(posedge clk);
            #1;
            $display("[TB] vec %0d phase %0d valid=%04h rdy=%0b -> arvalid=%0b sel=%04h addr=%08h",
                     i, vecs[i].phase, vecs[i].valid, vecs[i].rdy,
                     bus.s_axi_arvalid_o, bus.Master_ID_Selected_o, bus.s_axi_araddr_o);
            check_outputs($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_sel,
                          vecs[i].exp_ardy, vecs[i].exp_addr, vecs[i].exp_prot, vecs[i].exp_idx);
        end

        // Reset one cycle into BUSY discards the capture; master 15 is regranted after.
        do_reset();
        set_addrs(3);
        base = hs5000;
        bus.m_axi_arvalid_i = 16'h8000;
        bus.s_axi_arready_i = 1'b0;
        @(posedge clk); #1;
        check_outputs("rst.grant", 1'b1, 16'h8000, 16'h8000, 32'h5000, 3'b101, 4'd15);
        @(posedge clk); #1;
        check_outputs("rst.busy", 1'b1, 16'h8000, 16'h0000, 32'h5000, 3'b101, 4'd15);
        #2 rst = 1'b1;
        #1;
        check_outputs("rst.async", 1'b0, 16'h0, 16'h0, 32'h0, 3'd0, 4'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("rst.regrant", 1'b1, 16'h8000, 16'h8000, 32'h5000, 3'b101, 4'd15);
        bus.s_axi_arready_i = 1'b1;
        @(posedge clk); #1;
        bus.m_axi_arvalid_i = '0;
        bus.s_axi_arready_i = 1'b0;
        check_outputs("rst.accept", 1'b0, 16'h0, 16'h0, 32'h0, 3'd0, 4'd0);
        check("rst.hs5000", 32'(hs5000 - base), 32'd1);
        $display("[TB] reset-in-BUSY: 0x5000 presented %0d time(s)", hs5000 - base);

        // Weighted instance: masters 0 and 1 continuously valid, slave always ready.
        do_reset();
        bus_w.m_axi_arvalid_i = 16'h0003;
        bus_w.s_axi_arready_i = 1'b1;
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            @(posedge clk); #1;
            if (bus_w.m_axi_arready_o != '0) begin
                got.push_back(int'(bus_w.Master_ID_Index_o));
                $display("[TB] weighted grant %0d -> master %0d", got.size() - 1,
                         bus_w.Master_ID_Index_o);
            end
        end
        check("w.count", 32'(got.size()), 32'd8);
        foreach (got[i]) check($sformatf("w.grant%0d", i), 32'(got[i]), 32'(exp_w[i]));
        bus_w.m_axi_arvalid_i = '0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
